// File: rtl/cp0_pkg.sv
// CP0 register addresses, sequencer state encoding and interrupt entrance vectors
// shared by the ID-stage interrupt sequencer and its users.
package cp0_pkg;

    localparam logic [4:0] CP0_DISABLE = 5'h16;
    localparam logic [4:0] CP0_MASK    = 5'h17;
    localparam logic [4:0] CP0_EPC     = 5'h0e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ENTER   = 2'd1,
        ST_SERVICE = 2'd2,
        ST_RETURN  = 2'd3
    } seq_state_e;

    localparam logic [31:0] VEC2 = 32'h0000_0000;
    localparam logic [31:0] VEC1 = 32'h0000_0600;
    localparam logic [31:0] VEC0 = 32'h0000_0800;

    function automatic logic [31:0] irq_vector(input logic [1:0] idx);
        case (idx)
            2'd2:    irq_vector = VEC2;
            2'd1:    irq_vector = VEC1;
            default: irq_vector = VEC0;
        endcase
    endfunction

endpackage

// File: rtl/interrupt_sequencer_if.sv
// ID-stage bus between the pipeline (master) and the interrupt sequencer (slave):
// instruction qualifiers, CP0 access and the PC redirect / ID flush back-channel.
interface interrupt_sequencer_if;

    logic        id_valid;
    logic        stall_ID;
    logic [31:0] pc_next_ID;
    logic        eret_ID;
    logic        mtc0_ID;
    logic        mfc0_ID;
    logic [4:0]  cp0_addr_ID;
    logic [31:0] cp0_wdata_ID;
    logic [31:0] cp0_rdata;
    logic        redirect_valid;
    logic [31:0] pc_redirect;
    logic        flush_ID;

    modport master (
        output id_valid, stall_ID, pc_next_ID, eret_ID, mtc0_ID, mfc0_ID,
               cp0_addr_ID, cp0_wdata_ID,
        input  cp0_rdata, redirect_valid, pc_redirect, flush_ID
    );

    modport slave (
        input  id_valid, stall_ID, pc_next_ID, eret_ID, mtc0_ID, mfc0_ID,
               cp0_addr_ID, cp0_wdata_ID,
        output cp0_rdata, redirect_valid, pc_redirect, flush_ID
    );

endinterface

// File: rtl/irq_sync_edge.sv
// Per-bit 2-flop synchronizer followed by a registered rising-edge pulse; a rise
// sampled at edge N is presented as a one-cycle pulse after edge N+2.
module irq_sync_edge #(
    parameter int DATA_W = 3
) (
    input  logic              clk,
    input  logic              rst_ID,
    input  logic [DATA_W-1:0] irq_in,
    output logic [DATA_W-1:0] rise
);

    logic [DATA_W-1:0] sync_p0;
    logic [DATA_W-1:0] sync_p1;
    logic [DATA_W-1:0] sync_p2;

    always_ff @(posedge clk or posedge rst_ID) begin
        if (rst_ID) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
            sync_p2 <= '0;
            rise    <= '0;
        end else begin
            sync_p0 <= irq_in;
            sync_p1 <= sync_p0;
            // p2 only remembers the previous synchronized level for edge detect
            sync_p2 <= sync_p1;
            rise    <= sync_p1 & ~sync_p2;
        end
    end

endmodule

// File: rtl/interrupt_sequencer.sv
// ID-stage interrupt/CP0 controller: latches IO interrupts, serves mfc0/mtc0/eret and
// sequences entry/return redirects. Define NESTED_INT_EN for a 3-deep preemptive EPC stack.
module interrupt_sequencer
    import cp0_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_ID,
    input  logic [2:0]             irq_in,
    interrupt_sequencer_if.slave   id_bus,
    output logic                   int_take,
    output logic                   int_disable,
    output logic [2:0]             int_mask,
    output logic [2:0]             int_pending,
    output logic [31:0]            epc
);

    localparam logic [1:0] IDLE    = ST_IDLE;
    localparam logic [1:0] ENTER   = ST_ENTER;
    localparam logic [1:0] SERVICE = ST_SERVICE;
    localparam logic [1:0] RETURN  = ST_RETURN;

    logic [2:0] irq_rise;
    logic [2:0] elig;
    logic [2:0] pend_clr;
    logic [1:0] state;
    logic [1:0] state_nxt;
    logic [1:0] winner;
    logic [1:0] win_idx;
    logic       id_go;
    logic       take;
    logic       state_ok;
    logic       cp0_wr;
    logic       ret_done;
    logic       entry_sets_disable;

    irq_sync_edge #(.DATA_W(3)) u_irq_sync (
        .clk    (clk),
        .rst_ID (rst_ID),
        .irq_in (irq_in),
        .rise   (irq_rise)
    );

    assign id_go    = id_bus.id_valid && !id_bus.stall_ID;
    assign elig     = int_pending & int_mask;
    assign winner   = elig[2] ? 2'd2 : (elig[1] ? 2'd1 : 2'd0);
    // eret/mtc0 in ID change CP0 state, so the boundary is deferred past them
    assign take     = state_ok && !int_disable && (elig != 3'b000) && id_go
                      && !id_bus.eret_ID && !id_bus.mtc0_ID;
    assign cp0_wr   = id_bus.mtc0_ID && id_go && !id_bus.flush_ID;
    assign pend_clr = take ? (3'b001 << winner) : 3'b000;

`ifdef NESTED_INT_EN
    logic [31:0] epc_stk [0:2];
    logic [1:0]  lvl_stk [0:2];
    logic [1:0]  depth;
    logic [1:0]  top_idx;

    assign entry_sets_disable = 1'b0;
    assign top_idx  = (depth == 2'd0) ? 2'd0 : depth - 2'd1;
    assign state_ok = (state == IDLE)
                      || ((state == SERVICE) && (depth != 2'd3) && (winner > lvl_stk[top_idx]));
    assign ret_done = (depth == 2'd1);
    assign epc      = epc_stk[top_idx];

    always_ff @(posedge clk or posedge rst_ID) begin
        if (rst_ID) begin
            depth <= 2'd0;
            for (int i = 0; i < 3; i++) begin
                epc_stk[i] <= '0;
                lvl_stk[i] <= '0;
            end
        end else if (take) begin
            epc_stk[depth] <= id_bus.pc_next_ID;
            lvl_stk[depth] <= winner;
            depth          <= depth + 2'd1;
        end else if (state == RETURN) begin
            depth <= depth - 2'd1;
        end else if (cp0_wr && (id_bus.cp0_addr_ID == CP0_EPC)) begin
            epc_stk[top_idx] <= id_bus.cp0_wdata_ID;
        end
    end
`else
    logic [31:0] epc_q;

    assign entry_sets_disable = 1'b1;
    assign state_ok = (state == IDLE);
    assign ret_done = 1'b1;
    assign epc      = epc_q;

    always_ff @(posedge clk or posedge rst_ID) begin
        if (rst_ID) begin
            epc_q <= '0;
        end else if (take) begin
            epc_q <= id_bus.pc_next_ID;
        end else if (cp0_wr && (id_bus.cp0_addr_ID == CP0_EPC)) begin
            epc_q <= id_bus.cp0_wdata_ID;
        end
    end
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (take) state_nxt = ENTER;
            ENTER:   state_nxt = SERVICE;
            SERVICE: begin
                if (take)                              state_nxt = ENTER;
                else if (id_bus.eret_ID && id_go)      state_nxt = RETURN;
            end
            RETURN:  state_nxt = ret_done ? IDLE : SERVICE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_ID) begin
        if (rst_ID) begin
            state       <= IDLE;
            int_pending <= 3'b000;
            int_mask    <= 3'b000;
            int_disable <= 1'b1;
        end else begin
            state <= state_nxt;
            // a fresh edge on the bit being taken wins over its clear
            int_pending <= (int_pending & ~pend_clr) | irq_rise;
            if (cp0_wr && (id_bus.cp0_addr_ID == CP0_MASK)) begin
                int_mask <= id_bus.cp0_wdata_ID[2:0];
            end
            if (take && entry_sets_disable) begin
                int_disable <= 1'b1;
            end else if ((state == RETURN) && ret_done) begin
                int_disable <= 1'b0;
            end else if (cp0_wr && (id_bus.cp0_addr_ID == CP0_DISABLE)) begin
                int_disable <= id_bus.cp0_wdata_ID[0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (take) begin
            win_idx <= winner;
        end
    end

    assign int_take              = (state == ENTER);
    assign id_bus.redirect_valid = (state == ENTER) || (state == RETURN);
    assign id_bus.flush_ID       = (state == ENTER) || (state == RETURN);
    assign id_bus.pc_redirect    = (state == ENTER) ? irq_vector(win_idx) : epc;

    always_comb begin
        id_bus.cp0_rdata = '0;
        if (id_bus.mfc0_ID) begin
            case (id_bus.cp0_addr_ID)
                CP0_DISABLE: id_bus.cp0_rdata = {31'b0, int_disable};
                CP0_MASK:    id_bus.cp0_rdata = {29'b0, int_mask};
                CP0_EPC:     id_bus.cp0_rdata = epc;
                default:     id_bus.cp0_rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Scoreboarded bench for interrupt_sequencer: expected redirects are queued as
// stimulus is driven and popped when the DUT raises redirect_valid.
module tb_interrupt_sequencer;
    import cp0_pkg::*;

    logic        clk = 1'b0;
    logic        rst_ID;
    logic [2:0]  irq_in;
    logic        int_take;
    logic        int_disable;
    logic [2:0]  int_mask;
    logic [2:0]  int_pending;
    logic [31:0] epc;

    interrupt_sequencer_if bus ();

    interrupt_sequencer dut (
        .clk         (clk),
        .rst_ID      (rst_ID),
        .irq_in      (irq_in),
        .id_bus      (bus),
        .int_take    (int_take),
        .int_disable (int_disable),
        .int_mask    (int_mask),
        .int_pending (int_pending),
        .epc         (epc)
    );

    always #5 clk = ~clk;

`ifdef NESTED_INT_EN
    localparam logic [31:0] EXP_DIS_ENTRY = 32'd0;
`else
    localparam logic [31:0] EXP_DIS_ENTRY = 32'd1;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic [31:0] pc;
        logic        take;
    } redir_t;

    redir_t exp_q[$];
    redir_t mon_e;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    always @(negedge clk) begin
        if (!rst_ID && bus.redirect_valid) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_redirect", {31'b0, bus.redirect_valid}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check_eq("redir_pc", bus.pc_redirect, mon_e.pc);
                check_eq("redir_take", {31'b0, int_take}, {31'b0, mon_e.take});
                check_eq("redir_flush", {31'b0, bus.flush_ID}, 32'd1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic tk);
        redir_t e;
        e.pc   = pc;
        e.take = tk;
        exp_q.push_back(e);
    endtask

    task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
        bus.mtc0_ID      = 1'b1;
        bus.cp0_addr_ID  = addr;
        bus.cp0_wdata_ID = data;
        tick();
        bus.mtc0_ID      = 1'b0;
    endtask

    task automatic mfc0_chk(input string tag, input logic [4:0] addr, input logic [31:0] exp);
        bus.mfc0_ID     = 1'b1;
        bus.cp0_addr_ID = addr;
        #1;
        check_eq(tag, bus.cp0_rdata, exp);
        bus.mfc0_ID     = 1'b0;
    endtask

    // Pulse for one sampled edge, then wait until the request reaches int_pending.
    task automatic pulse_irq(input logic [2:0] bits);
        irq_in = bits;
        tick();
        irq_in = 3'b000;
        repeat (3) tick();
    endtask

    task automatic do_eret(input logic [31:0] ret_pc);
        push_exp(ret_pc, 1'b0);
        bus.eret_ID = 1'b1;
        tick();
        bus.eret_ID = 1'b0;
        tick();
    endtask

    initial begin
        rst_ID           = 1'b1;
        irq_in           = 3'b000;
        bus.id_valid     = 1'b1;
        bus.stall_ID     = 1'b0;
        bus.pc_next_ID   = 32'h0000_0010;
        bus.eret_ID      = 1'b0;
        bus.mtc0_ID      = 1'b0;
        bus.mfc0_ID      = 1'b0;
        bus.cp0_addr_ID  = 5'h00;
        bus.cp0_wdata_ID = 32'h0;

        repeat (2) tick();
        check_eq("rst_disable", {31'b0, int_disable}, 32'd1);
        check_eq("rst_mask", {29'b0, int_mask}, 32'd0);
        check_eq("rst_pending", {29'b0, int_pending}, 32'd0);
        check_eq("rst_epc", epc, 32'd0);
        check_eq("rst_redirect", {31'b0, bus.redirect_valid}, 32'd0);
        check_eq("rst_take", {31'b0, int_take}, 32'd0);
        mfc0_chk("rst_rdata0", 5'h00, 32'd0);
        rst_ID = 1'b0;
        tick();
        mfc0_chk("rd_disable_rst", CP0_DISABLE, 32'd1);

        // Enable all sources, then a single irq[1]
        mtc0(CP0_MASK, 32'h7);
        mtc0(CP0_DISABLE, 32'h0);
        mfc0_chk("rd_mask", CP0_MASK, 32'h7);
        mfc0_chk("rd_disable", CP0_DISABLE, 32'h0);
        bus.id_valid = 1'b0;
        irq_in = 3'b010;
        tick();
        irq_in = 3'b000;
        repeat (2) tick();
        check_eq("pend_not_yet", {29'b0, int_pending}, 32'd0);
        tick();
        check_eq("pend_irq1", {29'b0, int_pending}, 32'h2);
        bus.pc_next_ID = 32'h0000_0040;
        bus.id_valid   = 1'b1;
        push_exp(VEC1, 1'b1);
        tick();
        check_eq("epc_irq1", epc, 32'h40);
        check_eq("dis_entry", {31'b0, int_disable}, EXP_DIS_ENTRY);
        check_eq("pend_clr1", {29'b0, int_pending}, 32'd0);
        tick();
        mfc0_chk("rd_epc", CP0_EPC, 32'h40);
        do_eret(32'h40);
        check_eq("dis_after_ret", {31'b0, int_disable}, 32'd0);

        // irq[0] and irq[2] together: irq[2] first, then irq[0]
        bus.id_valid = 1'b0;
        pulse_irq(3'b101);
        check_eq("pend_101", {29'b0, int_pending}, 32'h5);
        bus.pc_next_ID = 32'h0000_0100;
        bus.id_valid   = 1'b1;
        push_exp(VEC2, 1'b1);
        tick();
        check_eq("pend_left_001", {29'b0, int_pending}, 32'h1);
        check_eq("epc_irq2", epc, 32'h100);
        tick();
        push_exp(32'h100, 1'b0);
        bus.eret_ID = 1'b1;
        tick();
        bus.eret_ID = 1'b0;
        push_exp(VEC0, 1'b1);
        bus.pc_next_ID = 32'h0000_0200;
        tick();
        tick();
        check_eq("epc_irq0", epc, 32'h200);
        check_eq("pend_empty", {29'b0, int_pending}, 32'd0);
        tick();
        do_eret(32'h200);

        // Masked source stays pending until the mask opens
        mtc0(CP0_MASK, 32'h1);
        pulse_irq(3'b100);
        tick();
        check_eq("masked_pend", {29'b0, int_pending}, 32'h4);
        bus.pc_next_ID = 32'h0000_0300;
        push_exp(VEC2, 1'b1);
        mtc0(CP0_MASK, 32'h4);
        tick();
        check_eq("epc_unmask", epc, 32'h300);
        check_eq("pend_unmask", {29'b0, int_pending}, 32'd0);
        tick();
        do_eret(32'h300);

        // Stall holds off the take; mtc0 in the release cycle defers it once more
        bus.id_valid = 1'b0;
        pulse_irq(3'b010);
        bus.id_valid   = 1'b1;
        bus.stall_ID   = 1'b1;
        bus.pc_next_ID = 32'h0000_0500;
        repeat (4) tick();
        check_eq("stall_pend", {29'b0, int_pending}, 32'h2);
        bus.stall_ID = 1'b0;
        mtc0(CP0_MASK, 32'h7);
        check_eq("mtc0_defer", {29'b0, int_pending}, 32'h2);
        push_exp(VEC1, 1'b1);
        tick();
        check_eq("epc_stall", epc, 32'h500);
        check_eq("pend_stall_clr", {29'b0, int_pending}, 32'd0);
        tick();
        do_eret(32'h500);

        // Reset during ENTER abandons the entry
        bus.id_valid = 1'b0;
        pulse_irq(3'b010);
        bus.id_valid = 1'b1;
        tick();
        rst_ID = 1'b1;
        #1;
        check_eq("rst_mid_redirect", {31'b0, bus.redirect_valid}, 32'd0);
        check_eq("rst_mid_pending", {29'b0, int_pending}, 32'd0);
        check_eq("rst_mid_disable", {31'b0, int_disable}, 32'd1);
        check_eq("rst_mid_epc", epc, 32'd0);
        tick();
        rst_ID = 1'b0;
        tick();

`ifdef NESTED_INT_EN
        // irq[2] preempts the irq[0] handler; two erets unwind the stack
        mtc0(CP0_MASK, 32'h7);
        mtc0(CP0_DISABLE, 32'h0);
        bus.id_valid = 1'b0;
        pulse_irq(3'b001);
        bus.pc_next_ID = 32'h0000_0040;
        bus.id_valid   = 1'b1;
        push_exp(VEC0, 1'b1);
        tick();
        tick();
        check_eq("nest_epc0", epc, 32'h40);
        bus.id_valid = 1'b0;
        pulse_irq(3'b100);
        tick();
        bus.pc_next_ID = 32'h0000_0880;
        bus.id_valid   = 1'b1;
        push_exp(VEC2, 1'b1);
        tick();
        check_eq("nest_epc1", epc, 32'h880);
        tick();
        do_eret(32'h880);
        check_eq("nest_pop_epc", epc, 32'h40);
        do_eret(32'h40);
        check_eq("nest_disable", {31'b0, int_disable}, 32'd0);
        check_eq("nest_pend", {29'b0, int_pending}, 32'd0);
`endif

        repeat (3) tick();
        check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
